mc_controller: RTL and testbench
================================

Name: mc_controller

Overview:
- Multicycle MIPS control unit: a Moore FSM plus a funct decoder that sequences each instruction and drives the datapath enables, mux selects and the 3-bit ALU function `f`.
- Sits directly upstream of the ALU. It consumes the ALU `zero` flag for branch resolution.
- Supported instructions: lw, sw, R-type (add/sub/and/or/slt), beq, bne, addi, j.

Parameters:
- None. Opcode, funct, state and ALU codes are fixed constants in the shared package.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; forces state to FETCH
- op  in  6  instruction[31:26], taken from the instruction register
- funct  in  6  instruction[5:0]
- zero  in  1  ALU zero flag from the current cycle
- pcen  out  1  PC load enable = pcwrite | (branch & (zero ^ bne_sel))
- memwrite  out  1  data memory write enable
- irwrite  out  1  instruction register load enable
- regwrite  out  1  register file write enable
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- memtoreg  out  1  writeback select: 0 = ALUOut, 1 = memory data
- regdst  out  1  destination select: 0 = rt, 1 = rd
- alusrca  out  1  ALU input A select: 0 = PC, 1 = register A
- alusrcb  out  2  ALU input B select: 00 = B, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm << 2
- pcsrc  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target
- alucontrol  out  3  drives ALU `f`: 010 add, 110 sub, 000 and, 001 or, 111 slt
- state_o  out  4  current state, exposed for debug and verification

Behaviour:
- State register: 4 bits, updates on rising clk. Asynchronous reset sets it to FETCH immediately.
- While reset is high, pcen, memwrite, irwrite and regwrite are forced to 0. All other outputs show the FETCH decode.
- Outputs are decoded combinationally from state. Exception: alucontrol in RTYPEEX also depends on funct. pcen also depends on zero.
- Defaults: every enable 0, every select 0, alucontrol 010, unless listed for the state below.

States and actions:
- FETCH: irwrite=1, pcwrite=1, alusrcb=01, alucontrol=010. Next state DECODE.
- DECODE: alusrcb=11, alucontrol=010 (branch target into ALUOut). Next state by op:
  - lw/sw -> MEMADR
  - R (000000) -> RTYPEEX
  - beq (000100) / bne (000101) -> BRANCHEX
  - addi (001000) -> ADDIEX
  - j (000010) -> JEX
  - any other op -> FETCH (treated as a NOP; no write enable asserted)
- MEMADR: alusrca=1, alusrcb=10, alucontrol=010. Next: lw (100011) -> MEMRD, sw (101011) -> MEMWR.
- MEMRD: iord=1. Next MEMWB.
- MEMWB: regwrite=1, memtoreg=1, regdst=0. Next FETCH.
- MEMWR: iord=1, memwrite=1. Next FETCH.
- RTYPEEX: alusrca=1, alusrcb=00, alucontrol from funct. Next RTYPEWB.
  - Funct map: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111.
  - Unknown funct -> 010 (still writes back).
- RTYPEWB: regwrite=1, regdst=1, memtoreg=0. Next FETCH.
- BRANCHEX: alusrca=1, alusrcb=00, alucontrol=110, branch=1, pcsrc=01.
  - bne_sel = op[0]: beq takes the branch on zero=1, bne on zero=0.
  - Next FETCH.
- ADDIEX: alusrca=1, alusrcb=10, alucontrol=010. Next ADDIWB.
- ADDIWB: regwrite=1, regdst=0, memtoreg=0. Next FETCH.
- JEX: pcsrc=10, pcwrite=1. Next FETCH.

Latency in cycles, FETCH to next FETCH: lw 5, sw 4, R 4, addi 4, beq/bne 3, j 3, unknown op 2.

Edge cases:
- Reset asserted mid-instruction abandons it with no further write enables. First FETCH occurs on the first rising edge after reset deasserts.
- `zero` is sampled only in BRANCHEX. In every other state it has no effect on any output.
- Unreachable state encodings -> next state FETCH, all enables 0.

Decomposition:
- Package mc_pkg holds:
  - state encodings (FETCH=0 … JEX=11)
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J)
  - funct constants
  - ALU code constants (ALU_AND=000, ALU_OR=001, ALU_ADD=010, ALU_SUB=110, ALU_SLT=111)
  - select encodings for alusrcb and pcsrc
- One combinational sub-module, mc_alu_decoder: inputs funct and an rtype qualifier, output alucontrol. Keeping it separate lets it be unit-tested against the ALU.

Test Plan:
- Reset pulse in MEMRD -> state_o=FETCH immediately; enables 0 while reset is high; first post-reset cycle has irwrite=1, pcen=1, alusrcb=01, alucontrol=010.
- op=100011 -> visits FETCH, DECODE, MEMADR, MEMRD, MEMWB; MEMWB has regwrite=1, memtoreg=1, regdst=0; back to FETCH on cycle 6.
- op=000000 for each funct 100000/100010/100100/100101/101010 -> alucontrol in RTYPEEX is 010/110/000/001/111; RTYPEWB has regwrite=1, regdst=1.
- op=000100 with zero=1 -> pcen=1, pcsrc=01 in BRANCHEX; with zero=0 -> pcen=0. op=000101 gives the inverse result for each zero value.
- op=000010 -> JEX has pcen=1, pcsrc=10 (3 cycles total). op=111111 -> DECODE returns to FETCH with no write enable asserted in either cycle.
- op=101011 -> MEMWR has memwrite=1, iord=1, regwrite=0; 4 cycles total. Toggling zero during MEMWR has no effect on pcen.

Source files
------------

// File: rtl/mc_pkg.sv
// mc_pkg: shared state, opcode, funct, ALU and select encodings for the multicycle MIPS controller.
package mc_pkg;
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMRD    = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWR    = 4'd5;
  localparam logic [3:0] S_RTYPEEX  = 4'd6;
  localparam logic [3:0] S_RTYPEWB  = 4'd7;
  localparam logic [3:0] S_BRANCHEX = 4'd8;
  localparam logic [3:0] S_ADDIEX   = 4'd9;
  localparam logic [3:0] S_ADDIWB   = 4'd10;
  localparam logic [3:0] S_JEX      = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_BRIMM = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
  } ctrl_t;
endpackage

// File: rtl/mc_alu_decoder.sv
// mc_alu_decoder: maps R-type funct to the ALU function code; non-R-type cycles get add.
module mc_alu_decoder
  import mc_pkg::*;
(
  input  logic [5:0] funct,
  input  logic       rtype,
  output logic [2:0] alucontrol
);
  always_comb
    alucontrol = !rtype           ? ALU_ADD :
                 funct == FN_SUB  ? ALU_SUB :
                 funct == FN_AND  ? ALU_AND :
                 funct == FN_OR   ? ALU_OR  :
                 funct == FN_SLT  ? ALU_SLT : ALU_ADD;
endmodule

// File: rtl/mc_controller.sv
// mc_controller: multicycle MIPS control FSM driving datapath enables, selects and ALU function.
module mc_controller
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic [3:0] state_o
);
  logic [3:0] state, next;
  ctrl_t      c;
  logic [2:0] dec_alu;

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= S_FETCH;
    else state <= next;

  always_comb begin
    next = S_FETCH;
    case (state)
      S_FETCH:   next = S_DECODE;
      S_DECODE:  next = (op == OP_LW || op == OP_SW)   ? S_MEMADR   :
                        op == OP_RTYPE                 ? S_RTYPEEX  :
                        (op == OP_BEQ || op == OP_BNE) ? S_BRANCHEX :
                        op == OP_ADDI                  ? S_ADDIEX   :
                        op == OP_J                     ? S_JEX      : S_FETCH;
      S_MEMADR:  next = op == OP_SW ? S_MEMWR : S_MEMRD;
      S_MEMRD:   next = S_MEMWB;
      S_RTYPEEX: next = S_RTYPEWB;
      S_ADDIEX:  next = S_ADDIWB;
      default:   next = S_FETCH;
    endcase
  end

  always_comb begin
    c = '0;
    case (state)
      S_FETCH:    begin c.irwrite = 1'b1; c.pcwrite = 1'b1; c.alusrcb = SRCB_FOUR; end
      S_DECODE:   c.alusrcb = SRCB_BRIMM;
      S_MEMADR:   begin c.alusrca = 1'b1; c.alusrcb = SRCB_IMM; end
      S_MEMRD:    c.iord = 1'b1;
      S_MEMWB:    begin c.regwrite = 1'b1; c.memtoreg = 1'b1; end
      S_MEMWR:    begin c.iord = 1'b1; c.memwrite = 1'b1; end
      S_RTYPEEX:  c.alusrca = 1'b1;
      S_RTYPEWB:  begin c.regwrite = 1'b1; c.regdst = 1'b1; end
      S_BRANCHEX: begin c.alusrca = 1'b1; c.branch = 1'b1; c.pcsrc = PC_ALUOUT; end
      S_ADDIEX:   begin c.alusrca = 1'b1; c.alusrcb = SRCB_IMM; end
      S_ADDIWB:   c.regwrite = 1'b1;
      S_JEX:      begin c.pcwrite = 1'b1; c.pcsrc = PC_JUMP; end
      default:    c = '0;
    endcase
  end

  mc_alu_decoder u_dec (
    .funct      (funct),
    .rtype      (state == S_RTYPEEX),
    .alucontrol (dec_alu)
  );

  // op[0] distinguishes bne from beq, inverting the sense of zero
  assign pcen       = !reset && (c.pcwrite || (c.branch && (zero ^ op[0])));
  assign memwrite   = !reset && c.memwrite;
  assign irwrite    = !reset && c.irwrite;
  assign regwrite   = !reset && c.regwrite;
  assign iord       = c.iord;
  assign memtoreg   = c.memtoreg;
  assign regdst     = c.regdst;
  assign alusrca    = c.alusrca;
  assign alusrcb    = c.alusrcb;
  assign pcsrc      = c.pcsrc;
  assign alucontrol = state == S_BRANCHEX ? ALU_SUB : dec_alu;
  assign state_o    = state;
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: directed literal checks plus randomized instruction stream against a trace model.
module tb_mc_controller;
  logic       clk = 1'b0, reset = 1'b1, zero = 1'b0;
  logic [5:0] op = 6'd0, funct = 6'd0;
  logic       pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state_o;
  int checks = 0, errors = 0;
  logic active = 1'b0;
  int exp_st = 0;

  typedef struct packed {
    logic pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alu;
  } outs_t;

  mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
    .iord(iord), .memtoreg(memtoreg), .regdst(regdst), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  function automatic logic [2:0] funct_alu(input logic [5:0] f);
    logic [5:0] fk [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
    logic [2:0] fv [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
    funct_alu = 3'b010;
    for (int i = 0; i < 5; i++) if (fk[i] == f) funct_alu = fv[i];
  endfunction

  // Output table keyed by the spec's numbered state names
  function automatic outs_t model(input int st, input logic [5:0] o, input logic [5:0] f, input logic z);
    outs_t e = '0;
    e.alu = 3'b010;
    case (st)
      0:  begin e.irwrite = 1; e.pcen = 1; e.alusrcb = 2'b01; end
      1:  e.alusrcb = 2'b11;
      2:  begin e.alusrca = 1; e.alusrcb = 2'b10; end
      3:  e.iord = 1;
      4:  begin e.regwrite = 1; e.memtoreg = 1; end
      5:  begin e.iord = 1; e.memwrite = 1; end
      6:  begin e.alusrca = 1; e.alu = funct_alu(f); end
      7:  begin e.regwrite = 1; e.regdst = 1; end
      8:  begin e.alusrca = 1; e.alu = 3'b110; e.pcsrc = 2'b01; e.pcen = (o == 6'd4) ? z : !z; end
      9:  begin e.alusrca = 1; e.alusrcb = 2'b10; end
      10: e.regwrite = 1;
      11: begin e.pcen = 1; e.pcsrc = 2'b10; end
      default: ;
    endcase
    return e;
  endfunction

  always @(negedge clk) if (active) begin
    outs_t a, e;
    e = model(exp_st, op, funct, zero);
    a = '{pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca, alusrcb, pcsrc, alucontrol};
    chk("state", int'(state_o), exp_st);
    chk("outs", int'(a), int'(e));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [5:0] o, input logic [5:0] f);
    int tr[$];
    op = o;
    funct = f;
    if (o == 6'h23) tr = {0, 1, 2, 3, 4};
    else if (o == 6'h2b) tr = {0, 1, 2, 5};
    else if (o == 6'h00) tr = {0, 1, 6, 7};
    else if (o == 6'h04 || o == 6'h05) tr = {0, 1, 8};
    else if (o == 6'h08) tr = {0, 1, 9, 10};
    else if (o == 6'h02) tr = {0, 1, 11};
    else tr = {0, 1};
    foreach (tr[k]) begin
      exp_st = tr[k];
      zero = 1'($urandom);
      active = 1'b1;
      step();
    end
  endtask

  initial begin
    logic [5:0] fn [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
    int fa [5] = '{2, 6, 0, 1, 7};
    int br [4][3] = '{'{4, 0, 0}, '{4, 1, 1}, '{5, 0, 1}, '{5, 1, 0}};
    logic [5:0] ops [8] = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h08, 6'h02, 6'h3f};
    #13;
    chk("rst_state", int'(state_o), 0);
    chk("rst_enables", int'({pcen, memwrite, irwrite, regwrite}), 0);
    chk("rst_alusrcb", int'(alusrcb), 1);
    #3 reset = 1'b0;
    #1;
    chk("fetch_enables", int'({irwrite, pcen}), 3);
    chk("fetch_sel", int'({alusrcb, alucontrol}), 5'b01_010);
    op = 6'h23;
    for (int k = 0; k < 5; k++) begin
      chk("lw_state", int'(state_o), k);
      if (k == 4) chk("lw_wb", int'({regwrite, memtoreg, regdst}), 3'b110);
      step();
    end
    chk("lw_back", int'(state_o), 0);
    op = 6'h00;
    for (int i = 0; i < 5; i++) begin
      funct = fn[i];
      step(); step();
      chk("r_alu", int'(alucontrol), fa[i]);
      step();
      chk("r_wb", int'({regwrite, regdst}), 3);
      step();
    end
    for (int i = 0; i < 4; i++) begin
      op = 6'(br[i][0]);
      step(); step();
      zero = 1'(br[i][1]);
      #1;
      chk("br_pcen", int'(pcen), br[i][2]);
      chk("br_pcsrc", int'(pcsrc), 1);
      step();
    end
    op = 6'h02;
    step(); step();
    chk("j_ex", int'({pcen, pcsrc}), 3'b110);
    step();
    chk("j_back", int'(state_o), 0);
    op = 6'h3f;
    chk("nop_fetch_wr", int'({memwrite, regwrite}), 0);
    step();
    chk("nop_decode_wr", int'({memwrite, regwrite, irwrite, pcen}), 0);
    step();
    chk("nop_back", int'(state_o), 0);
    op = 6'h2b;
    step(); step(); step();
    zero = 1'b0;
    #1;
    chk("sw_mem", int'({memwrite, iord, regwrite, pcen}), 4'b1100);
    zero = 1'b1;
    #1;
    chk("sw_zero_pcen", int'(pcen), 0);
    step();
    chk("sw_back", int'(state_o), 0);
    op = 6'h23;
    step(); step(); step();
    chk("mid_memrd", int'(state_o), 3);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_state", int'(state_o), 0);
    chk("mid_rst_en", int'({pcen, memwrite, irwrite, regwrite}), 0);
    step();
    chk("hold_rst_en", int'({pcen, memwrite, irwrite, regwrite, state_o}), 0);
    reset = 1'b0;
    #1;
    chk("post_rst_fetch", int'({irwrite, pcen, alusrcb, alucontrol}), 7'b11_01_010);
    for (int n = 0; n < 80; n++) begin
      logic [5:0] o, f;
      o = ops[$urandom_range(0, 7)];
      if (o == 6'h3f) o = 6'($urandom);
      f = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fn[$urandom_range(0, 4)];
      run_instr(o, f);
    end
    active = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
